// File: rtl/pcs_pkg.sv
// Code-group constants and transmit state encoding shared by the 1000BASE-X PCS TX path.
package pcs_pkg;

  localparam logic [7:0] CG_K28_5   = 8'hBC;
  localparam logic [7:0] CG_D5_6    = 8'hC5;
  localparam logic [7:0] CG_D16_2   = 8'h50;
  localparam logic [7:0] CG_S       = 8'hFB;
  localparam logic [7:0] CG_T       = 8'hFD;
  localparam logic [7:0] CG_R       = 8'hF7;
  localparam logic [7:0] CG_V       = 8'hFE;
  // GMII TXD value that qualifies TX_ER as carrier extension
  localparam logic [7:0] CG_EXT_TXD = 8'h0F;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PKT,
    END_R,
    END_R2,
    EXTEND,
    EXT_ALIGN
  } tx_state_e;

endpackage

// File: rtl/pcs_cg_timer.sv
// Code-group slot timer: modulo-CG_DIV counter with a one-clock boundary strobe.
module pcs_cg_timer #(
  parameter int unsigned CG_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic cg_timer_done
);

  localparam int unsigned TW = (CG_DIV > 1) ? $clog2(CG_DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(CG_DIV - 1);

  logic [TW-1:0] cnt_q;

  assign cg_timer_done = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cg_timer_done) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

endmodule

// File: rtl/pcs_tx_oset_gen.sv
// 1000BASE-X PCS transmit ordered-set generator: GMII TXD/TX_EN/TX_ER to code-group octet,
// K flag and slot parity, with packet framing, idle selection, carrier extension and counters.
module pcs_tx_oset_gen
  import pcs_pkg::*;
#(
  parameter int unsigned CG_DIV = 1,
  parameter bit          EXT_EN = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             mr_main_reset,
  input  logic             xmit_data,
  input  logic [7:0]       TXD,
  input  logic             TX_EN,
  input  logic             TX_ER,
  input  logic             rd_pos,
  output logic [7:0]       tx_code_group,
  output logic             tx_cg_k,
  output logic             tx_even,
  output logic             cg_timer_done,
  output logic [CNT_W-1:0] tx_pkt_cnt,
  output logic [CNT_W-1:0] tx_err_cnt
);

  tx_state_e  state_q, state_d;
  logic       rd_lat_q, rd_lat_d;
  logic [7:0] cg_d;
  logic       k_d;
  logic       pkt_inc, err_inc;
  logic       idle_slot;
  logic       slot_even;
  logic       ext_carrier, ext_hold, start_ok;

  pcs_cg_timer #(
    .CG_DIV(CG_DIV)
  ) u_timer (
    .clk          (clk),
    .rst_n        (mr_main_reset),
    .cg_timer_done(cg_timer_done)
  );

  // Parity of the slot whose code-group is produced at the coming boundary.
  assign slot_even   = ~tx_even;
  assign ext_carrier = EXT_EN && !TX_EN && TX_ER;
  assign ext_hold    = ext_carrier && (TXD == CG_EXT_TXD);
  assign start_ok    = xmit_data && TX_EN && !TX_ER;

  // Idle generation is shared by IDLE, EXT_ALIGN and an even-aligned EXTEND exit,
  // so a packet may start in the very first even slot after extension ends.
  always_comb begin
    state_d   = state_q;
    cg_d      = tx_code_group;
    k_d       = tx_cg_k;
    rd_lat_d  = rd_lat_q;
    pkt_inc   = 1'b0;
    err_inc   = 1'b0;
    idle_slot = 1'b0;

    case (state_q)
      START, PKT: begin
        if (!TX_EN) begin
          cg_d    = CG_T;
          k_d     = 1'b1;
          state_d = END_R;
        end else if (TX_ER) begin
          cg_d    = CG_V;
          k_d     = 1'b1;
          err_inc = 1'b1;
          state_d = PKT;
        end else begin
          cg_d    = TXD;
          k_d     = 1'b0;
          state_d = PKT;
        end
      end
      END_R, END_R2: begin
        cg_d = CG_R;
        k_d  = 1'b1;
        if (ext_hold) begin
          state_d = EXTEND;
        end else if ((state_q == END_R) && slot_even) begin
          state_d = END_R2;
        end else begin
          state_d = IDLE;
        end
      end
      EXTEND: begin
        if (ext_hold) begin
          cg_d = CG_R;
          k_d  = 1'b1;
        end else if (ext_carrier) begin
          cg_d    = CG_V;
          k_d     = 1'b1;
          err_inc = 1'b1;
        end else if (slot_even) begin
          idle_slot = 1'b1;
        end else begin
          cg_d    = CG_R;
          k_d     = 1'b1;
          state_d = EXT_ALIGN;
        end
      end
      default: idle_slot = 1'b1;
    endcase

    if (idle_slot) begin
      state_d = IDLE;
      if (!slot_even) begin
        cg_d = rd_lat_q ? CG_D5_6 : CG_D16_2;
        k_d  = 1'b0;
      end else if (start_ok) begin
        cg_d    = CG_S;
        k_d     = 1'b1;
        pkt_inc = 1'b1;
        state_d = START;
      end else begin
        cg_d     = CG_K28_5;
        k_d      = 1'b1;
        rd_lat_d = rd_pos;
      end
    end
  end

  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q       <= IDLE;
      rd_lat_q      <= 1'b0;
      tx_code_group <= CG_D16_2;
      tx_cg_k       <= 1'b0;
      tx_even       <= 1'b0;
      tx_pkt_cnt    <= '0;
      tx_err_cnt    <= '0;
    end else if (cg_timer_done) begin
      state_q       <= state_d;
      rd_lat_q      <= rd_lat_d;
      tx_code_group <= cg_d;
      tx_cg_k       <= k_d;
      tx_even       <= slot_even;
      if (pkt_inc && (tx_pkt_cnt != '1)) begin
        tx_pkt_cnt <= tx_pkt_cnt + CNT_W'(1);
      end
      if (err_inc && (tx_err_cnt != '1)) begin
        tx_err_cnt <= tx_err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pcs_tx_oset_gen.sv
// Bench for pcs_tx_oset_gen: three configurations driven in parallel against a slot-level reference model.
module tb_pcs_tx_oset_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       xmit_data;
  logic [7:0] txd;
  logic       tx_en, tx_er, rd_pos;

  logic [7:0]  cg1, cg0, cg4;
  logic        k1, k0, k4, ev1, ev0, ev4, d1, d0, d4;
  logic [15:0] pc1, ec1, pc4, ec4;
  logic [1:0]  pc0, ec0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned clk_n = 0;

  always #5 clk = ~clk;

  pcs_tx_oset_gen #(.CG_DIV(1), .EXT_EN(1'b1), .CNT_W(16)) u_dut1 (
    .clk(clk), .mr_main_reset(rst_n), .xmit_data(xmit_data), .TXD(txd), .TX_EN(tx_en),
    .TX_ER(tx_er), .rd_pos(rd_pos), .tx_code_group(cg1), .tx_cg_k(k1), .tx_even(ev1),
    .cg_timer_done(d1), .tx_pkt_cnt(pc1), .tx_err_cnt(ec1));

  pcs_tx_oset_gen #(.CG_DIV(1), .EXT_EN(1'b0), .CNT_W(2)) u_dut0 (
    .clk(clk), .mr_main_reset(rst_n), .xmit_data(xmit_data), .TXD(txd), .TX_EN(tx_en),
    .TX_ER(tx_er), .rd_pos(rd_pos), .tx_code_group(cg0), .tx_cg_k(k0), .tx_even(ev0),
    .cg_timer_done(d0), .tx_pkt_cnt(pc0), .tx_err_cnt(ec0));

  pcs_tx_oset_gen #(.CG_DIV(4), .EXT_EN(1'b1), .CNT_W(16)) u_dut4 (
    .clk(clk), .mr_main_reset(rst_n), .xmit_data(xmit_data), .TXD(txd), .TX_EN(tx_en),
    .TX_ER(tx_er), .rd_pos(rd_pos), .tx_code_group(cg4), .tx_cg_k(k4), .tx_even(ev4),
    .cg_timer_done(d4), .tx_pkt_cnt(pc4), .tx_err_cnt(ec4));

  // Reference model: one call per code-group slot, expressed as link modes.
  typedef enum {M_IDLE, M_DATA, M_TAIL, M_EXT} mode_e;
  typedef struct {
    mode_e       mode;
    bit          rd;
    bit          even;
    logic [7:0]  cg;
    bit          k;
    int unsigned pkts;
    int unsigned errs;
    int unsigned cmax;
  } mdl_t;

  mdl_t m1, m0, m4;

  function automatic mdl_t mdl_reset(input int unsigned cmax);
    mdl_t m;
    m.mode = M_IDLE; m.rd = 1'b0; m.even = 1'b0; m.cg = 8'h50; m.k = 1'b0;
    m.pkts = 0; m.errs = 0; m.cmax = cmax;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t mi, input bit ext_en, input bit xd,
                                    input logic [7:0] d, input bit en, input bit er, input bit rd);
    mdl_t m = mi;
    bit slot_even = !mi.even;
    bit go_idle = 1'b0;
    bit ext = ext_en && !en && er;
    m.even = slot_even;
    case (mi.mode)
      M_DATA: begin
        if (!en) begin m.cg = 8'hFD; m.k = 1'b1; m.mode = M_TAIL; end
        else if (er) begin
          m.cg = 8'hFE; m.k = 1'b1;
          if (m.errs < m.cmax) m.errs++;
        end else begin m.cg = d; m.k = 1'b0; end
      end
      M_TAIL: begin
        // /R/ continues until one lands in an odd slot, unless extension takes over
        m.cg = 8'hF7; m.k = 1'b1;
        if (ext && d == 8'h0F) m.mode = M_EXT;
        else if (!slot_even) m.mode = M_IDLE;
      end
      M_EXT: begin
        if (ext && d == 8'h0F) begin m.cg = 8'hF7; m.k = 1'b1; end
        else if (ext) begin
          m.cg = 8'hFE; m.k = 1'b1;
          if (m.errs < m.cmax) m.errs++;
        end else if (slot_even) go_idle = 1'b1;
        else begin m.cg = 8'hF7; m.k = 1'b1; m.mode = M_IDLE; end
      end
      default: go_idle = 1'b1;
    endcase
    if (go_idle) begin
      m.mode = M_IDLE;
      if (!slot_even) begin
        m.cg = m.rd ? 8'hC5 : 8'h50; m.k = 1'b0;
      end else if (xd && en && !er) begin
        m.cg = 8'hFB; m.k = 1'b1; m.mode = M_DATA;
        if (m.pkts < m.cmax) m.pkts++;
      end else begin
        m.cg = 8'hBC; m.k = 1'b1; m.rd = rd;
      end
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cg1", 32'(cg1), 32'(m1.cg));   chk("k1", 32'(k1), 32'(m1.k));
    chk("even1", 32'(ev1), 32'(m1.even)); chk("done1", 32'(d1), 32'd1);
    chk("pkt1", 32'(pc1), m1.pkts);      chk("err1", 32'(ec1), m1.errs);
    chk("cg0", 32'(cg0), 32'(m0.cg));   chk("k0", 32'(k0), 32'(m0.k));
    chk("even0", 32'(ev0), 32'(m0.even)); chk("done0", 32'(d0), 32'd1);
    chk("pkt0", 32'(pc0), m0.pkts);      chk("err0", 32'(ec0), m0.errs);
    chk("cg4", 32'(cg4), 32'(m4.cg));   chk("k4", 32'(k4), 32'(m4.k));
    chk("even4", 32'(ev4), 32'(m4.even));
    chk("done4", 32'(d4), (clk_n % 4 == 3) ? 32'd1 : 32'd0);
    chk("pkt4", 32'(pc4), m4.pkts);      chk("err4", 32'(ec4), m4.errs);
  endtask

  // Drive one input set for `hold` clocks; models advance on their own slot boundaries.
  task automatic cyc(input logic [7:0] d, input bit en, input bit er, input bit xd,
                     input int unsigned hold);
    for (int unsigned i = 0; i < hold; i++) begin
      txd = d; tx_en = en; tx_er = er; xmit_data = xd;
      rd_pos = 1'($urandom_range(0, 1));
      m1 = mdl_step(m1, 1'b1, xd, d, en, er, rd_pos);
      m0 = mdl_step(m0, 1'b0, xd, d, en, er, rd_pos);
      if (clk_n % 4 == 3) m4 = mdl_step(m4, 1'b1, xd, d, en, er, rd_pos);
      clk_n++;
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic episode(input int unsigned hold);
    bit xd = ($urandom_range(0, 7) != 0);
    int unsigned gap = $urandom_range(0, 3);
    int unsigned len = $urandom_range(1, 7);
    int unsigned ext = $urandom_range(0, 3);
    for (int unsigned i = 0; i < gap; i++)
      cyc(8'($urandom), 1'b0, ($urandom_range(0, 5) == 0), xd, hold);
    for (int unsigned i = 0; i < len; i++)
      cyc(8'($urandom), 1'b1, ($urandom_range(0, 7) == 0), xd, hold);
    for (int unsigned i = 0; i < ext; i++)
      cyc(($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h0F, 1'b0, 1'b1, xd, hold);
  endtask

  logic [7:0] dir_txd [9] = '{8'h55, 8'h55, 8'hD5, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] dir_exp [9] = '{8'hFB, 8'h55, 8'hD5, 8'h01, 8'h02, 8'hFD, 8'hF7, 8'hF7, 8'hBC};

  initial begin
    rst_n = 1'b0; xmit_data = 1'b0; txd = '0; tx_en = 1'b0; tx_er = 1'b0; rd_pos = 1'b0;
    m1 = mdl_reset(32'hFFFF); m0 = mdl_reset(3); m4 = mdl_reset(32'hFFFF);
    clk_n = 0;
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Packet starting in the first (even) slot after reset
    for (int i = 0; i < 9; i++) begin
      cyc(dir_txd[i], (i < 5), 1'b0, 1'b1, 1);
      chk("dir_seq", 32'(cg1), 32'(dir_exp[i]));
    end
    chk("dir_pkts", 32'(pc1), 32'd1);

    // TX_EN rising in an odd slot, then extension after /T/
    cyc(8'h55, 1'b1, 1'b0, 1'b1, 1);
    for (int i = 0; i < 4; i++) cyc(8'hA0 + 8'(i), 1'b1, 1'b0, 1'b1, 1);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1);
    repeat (3) cyc(8'h0F, 1'b0, 1'b1, 1'b1, 1);
    repeat (4) cyc(8'h00, 1'b0, 1'b0, 1'b1, 1);

    repeat (60) episode(1);
    repeat (30) episode(4);

    // Reset asserted mid-packet, away from any clock edge
    repeat (3) cyc(8'h33, 1'b1, 1'b0, 1'b1, 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    m1 = mdl_reset(32'hFFFF); m0 = mdl_reset(3); m4 = mdl_reset(32'hFFFF);
    clk_n = 0;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) episode(1);
    repeat (5) episode(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
